// File: rtl/step_request_scheduler_if.sv
// step_request_scheduler_if
//   Button-level inputs and step-pulse outputs between the debounce
//   front end, the step scheduler and the Gray-code counter.
//   master: drives the enable and debounced levels, observes the pulses.
//   slave : the scheduler itself.
interface step_request_scheduler_if;
    logic EN;        // 1 = stepping allowed
    logic UP_IN;     // debounced UP button level
    logic DOWN_IN;   // debounced DOWN button level
    logic UP;        // one-cycle step-up pulse
    logic DOWN;      // one-cycle step-down pulse
    logic ACTIVE;    // scheduler is not idle
    logic CONFLICT;  // scheduler is locked out by a conflicting press

    modport master (
        output EN, UP_IN, DOWN_IN,
        input  UP, DOWN, ACTIVE, CONFLICT
    );

    modport slave (
        input  EN, UP_IN, DOWN_IN,
        output UP, DOWN, ACTIVE, CONFLICT
    );
endinterface : step_request_scheduler_if

// File: rtl/step_request_scheduler.sv
// step_request_scheduler
//   Turns debounced UP/DOWN button levels into single-cycle step pulses
//   for the Gray-code counter. A clean press gives one pulse in the cycle
//   after the level is first sampled high; pressing both buttons, or the
//   other button while one is held, locks the scheduler out until both
//   buttons are released. EN=0 suppresses every pulse.
//
//   Build option: define AUTO_REPEAT_EN to make a held button repeat,
//   first after HOLD_CYCLES and then every REPEAT_CYCLES. Without it the
//   hold timer is not built and each press yields exactly one pulse.
//
//   Clocking: single clock CLK, synchronous active-high reset RST.
module step_request_scheduler #(
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int unsigned TMR_W         = 25
) (
    input  logic                     CLK,
    input  logic                     RST,
    step_request_scheduler_if.slave  bus
);

    // Configuration sanity: repeat intervals below 2 collide with the
    // press pulse, and the timer must be able to reach the last count.
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("HOLD_CYCLES and REPEAT_CYCLES must both be >= 2");
    end
    if ((64'(HOLD_CYCLES) - 64'd1) > ((64'd1 << TMR_W) - 64'd1) ||
        (64'(REPEAT_CYCLES) - 64'd1) > ((64'd1 << TMR_W) - 64'd1)) begin : g_bad_tmr_w
        $error("TMR_W too narrow for HOLD_CYCLES/REPEAT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD_UP = 2'd1,
        S_HOLD_DN = 2'd2,
        S_LOCKOUT = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Previous button levels for press detection. They come out of reset
    // at 1 so a button already held during reset never counts as a press.
    logic up_q,   down_q;

    // Registered outputs.
    logic up_pulse_q,  up_pulse_d;
    logic dn_pulse_q,  dn_pulse_d;
    logic active_q,    active_d;
    logic conflict_q,  conflict_d;

    logic press_up;
    logic press_dn;
    logic own_level;
    logic other_level;

`ifdef AUTO_REPEAT_EN
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_SAT     = {TMR_W{1'b1}};

    logic [TMR_W-1:0] timer_q, timer_d;
    // Set on entry to a hold state: the next repeat is the long first one.
    logic             first_pend_q, first_pend_d;
    logic             repeat_due;
`endif

    assign press_up = bus.UP_IN   & ~up_q;
    assign press_dn = bus.DOWN_IN & ~down_q;

    // In a hold state, "own" is the button that started the hold.
    assign own_level   = (state_q == S_HOLD_UP) ? bus.UP_IN   : bus.DOWN_IN;
    assign other_level = (state_q == S_HOLD_UP) ? bus.DOWN_IN : bus.UP_IN;

`ifdef AUTO_REPEAT_EN
    assign repeat_due = first_pend_q ? (timer_q == HOLD_LAST)
                                     : (timer_q == REPEAT_LAST);
`endif

    // Next-state, pulse and timer decision for the current cycle.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        up_pulse_d = 1'b0;
        dn_pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        // Cleared unless the FSM stays in a hold state this cycle.
        timer_d      = '0;
        first_pend_d = first_pend_q;
`endif

        if (!bus.EN) begin
            // Disabled: never pulse; a still-held button must be released
            // before it can count as a press again.
            state_d = (bus.UP_IN | bus.DOWN_IN) ? S_LOCKOUT : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (press_up && !bus.DOWN_IN) begin
                        up_pulse_d = 1'b1;
                        state_d    = S_HOLD_UP;
                    end else if (press_dn && !bus.UP_IN) begin
                        dn_pulse_d = 1'b1;
                        state_d    = S_HOLD_DN;
                    end else if (press_up || press_dn) begin
                        // A press while the other button is high, including
                        // both pressed on the same edge.
                        state_d = S_LOCKOUT;
                    end
`ifdef AUTO_REPEAT_EN
                    first_pend_d = 1'b1;
`endif
                end

                S_HOLD_UP, S_HOLD_DN: begin
                    // Conflict wins over release when both happen together.
                    if (other_level) begin
                        state_d = S_LOCKOUT;
                    end else if (!own_level) begin
                        state_d = S_IDLE;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        if (repeat_due) begin
                            up_pulse_d   = (state_q == S_HOLD_UP);
                            dn_pulse_d   = (state_q == S_HOLD_DN);
                            first_pend_d = 1'b0;
                        end else if (timer_q != TMR_SAT) begin
                            timer_d = timer_q + 1'b1;
                        end else begin
                            timer_d = timer_q;
                        end
`endif
                    end
                end

                S_LOCKOUT: begin
                    if (!bus.UP_IN && !bus.DOWN_IN) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        active_d   = (state_d != S_IDLE);
        conflict_d = (state_d == S_LOCKOUT);
    end

    // State, level history and output registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q    <= S_IDLE;
            up_q       <= 1'b1;
            down_q     <= 1'b1;
            up_pulse_q <= 1'b0;
            dn_pulse_q <= 1'b0;
            active_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_q       <= bus.UP_IN;
            down_q     <= bus.DOWN_IN;
            up_pulse_q <= up_pulse_d;
            dn_pulse_q <= dn_pulse_d;
            active_q   <= active_d;
            conflict_q <= conflict_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Hold timer and first-repeat flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q      <= '0;
            first_pend_q <= 1'b1;
        end else begin
            timer_q      <= timer_d;
            first_pend_q <= first_pend_d;
        end
    end
`endif

    assign bus.UP       = up_pulse_q;
    assign bus.DOWN     = dn_pulse_q;
    assign bus.ACTIVE   = active_q;
    assign bus.CONFLICT = conflict_q;

endmodule : step_request_scheduler

// File: tb/tb_step_request_scheduler.sv
// tb_step_request_scheduler
//   Directed scenarios plus a randomized run, all checked cycle by cycle
//   against a behavioural model of the button rules. Inputs change on the
//   falling edge; outputs are compared on the following falling edge.
module tb_step_request_scheduler;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    step_request_scheduler_if bus ();

    step_request_scheduler #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .TMR_W        (4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // ---------------------------------------------------------------
    // Behavioural model: which button currently owns the scheduler,
    // whether it is locked out, and how many edges have passed since
    // the last pulse of the held button.
    // ---------------------------------------------------------------
    int   m_owner  = 0;     // 0 none, 1 up, 2 down
    bit   m_locked = 1'b0;
    int   m_since  = 0;
    int   m_nrep   = 0;
    bit   m_prev_u = 1'b1;
    bit   m_prev_d = 1'b1;
    logic [3:0] exp_out = 4'b0000;   // {UP, DOWN, ACTIVE, CONFLICT}

    function automatic bit auto_repeat();
`ifdef AUTO_REPEAT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_edge(input bit r, input bit e, input bit u, input bit d);
        bit eu = 1'b0;
        bit ed = 1'b0;
        bit pu;
        bit pd;
        if (r) begin
            m_owner = 0; m_locked = 1'b0; m_since = 0; m_nrep = 0;
            m_prev_u = 1'b1; m_prev_d = 1'b1;
            exp_out = 4'b0000;
            return;
        end
        pu = u && !m_prev_u;
        pd = d && !m_prev_d;
        if (!e) begin
            m_owner  = 0;
            m_locked = u || d;
        end else if (m_locked) begin
            if (!u && !d) m_locked = 1'b0;
        end else if (m_owner == 0) begin
            if (pu && !d) begin
                eu = 1'b1; m_owner = 1; m_since = 0; m_nrep = 0;
            end else if (pd && !u) begin
                ed = 1'b1; m_owner = 2; m_since = 0; m_nrep = 0;
            end else if (pu || pd) begin
                m_locked = 1'b1;
            end
        end else begin
            bit own   = (m_owner == 1) ? u : d;
            bit other = (m_owner == 1) ? d : u;
            if (other) begin
                m_owner = 0; m_locked = 1'b1;
            end else if (!own) begin
                m_owner = 0;
            end else begin
                m_since++;
                if (auto_repeat() && m_since == ((m_nrep == 0) ? HOLD : REP)) begin
                    eu = (m_owner == 1);
                    ed = (m_owner == 2);
                    m_since = 0;
                    m_nrep++;
                end
            end
        end
        m_prev_u = u;
        m_prev_d = d;
        exp_out  = {eu, ed, (m_owner != 0) || m_locked, m_locked};
    endfunction

    // Drive one cycle of inputs (called on a falling edge), let the DUT and
    // model see the rising edge, and return on the next falling edge.
    task automatic step(input bit r, input bit e, input bit u, input bit d);
        RST         = r;
        bus.EN      = e;
        bus.UP_IN   = u;
        bus.DOWN_IN = d;
        @(posedge CLK);
        model_edge(r, e, u, d);
        @(negedge CLK);
    endtask

    function automatic logic [3:0] observed();
        return {bus.UP, bus.DOWN, bus.ACTIVE, bus.CONFLICT};
    endfunction

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] obs;
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        obs = observed();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", obs, 4'b0000);
        end
        // UP held through reset is not a press.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0);
            obs = observed();
            n_checks++;
            if (obs !== 4'b0000 || obs !== exp_out) begin
                n_fail++;
                $display("FAIL held_through_reset cyc=%0d got=%b want=%b", i, obs, 4'b0000);
            end
        end
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        obs = observed();
        n_checks++;
        if (obs !== 4'b1010 || obs !== exp_out) begin
            n_fail++;
            $display("FAIL repress_after_reset got=%b want=%b", obs, 4'b1010);
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
    endtask

    task automatic test_single_press();
        logic [3:0] want [4] = '{4'b1010, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] obs;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i < 3), 0);
            obs = observed();
            n_checks++;
            if (obs !== want[i] || obs !== exp_out) begin
                n_fail++;
                $display("FAIL single_press cyc=%0d got=%b want=%b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_conflict_same_cycle();
        logic [3:0] obs;
        logic [3:0] want;
        for (int i = 0; i < 6; i++) begin
            // both for 3 cycles, DOWN alone for 2, then both low
            step(0, 1, (i < 3), (i < 5));
            want = (i < 5) ? 4'b0011 : 4'b0000;
            obs  = observed();
            n_checks++;
            if (obs !== want || obs !== exp_out) begin
                n_fail++;
                $display("FAIL conflict_same_cycle cyc=%0d got=%b want=%b", i, obs, want);
            end
        end
    endtask

    task automatic test_down_then_up();
        logic [3:0] want [5] = '{4'b0110, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
        bit         ups  [5] = '{0, 0, 0, 1, 0};
        bit         dns  [5] = '{1, 1, 1, 1, 0};
        logic [3:0] obs;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, ups[i], dns[i]);
            obs = observed();
            n_checks++;
            if (obs !== want[i] || obs !== exp_out) begin
                n_fail++;
                $display("FAIL down_then_up cyc=%0d got=%b want=%b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [3:0] obs;
        bit         want_up;
        int         t;
        for (int i = 0; i < 31; i++) begin
            step(0, 1, (i < 30), 0);
            t = i + 1;
            want_up = (t == 1) ||
                      (auto_repeat() && t >= 9 && t <= 30 && ((t - 9) % 4) == 0);
            obs = observed();
            n_checks++;
            if (obs[3] !== want_up || obs[2] !== 1'b0 || obs !== exp_out) begin
                n_fail++;
                $display("FAIL auto_repeat t=%0d got=%b want_up=%b model=%b", t, obs, want_up, exp_out);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] obs;
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
        // This edge would carry the first repeat; reset must swallow it.
        step(1, 1, 1, 0);
        obs = observed();
        n_checks++;
        if (obs !== 4'b0000 || obs !== exp_out) begin
            n_fail++;
            $display("FAIL reset_mid_hold got=%b want=%b", obs, 4'b0000);
        end
        step(0, 1, 1, 0);
        obs = observed();
        n_checks++;
        if (obs !== 4'b0000 || obs !== exp_out) begin
            n_fail++;
            $display("FAIL after_reset_mid_hold got=%b want=%b", obs, 4'b0000);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_enable();
        logic [3:0] want [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b1010, 4'b0000};
        bit         ens  [6] = '{0, 1, 1, 1, 1, 1};
        bit         ups  [6] = '{1, 1, 1, 0, 1, 0};
        logic [3:0] obs;
        for (int i = 0; i < 6; i++) begin
            step(0, ens[i], ups[i], 0);
            obs = observed();
            n_checks++;
            if (obs !== want[i] || obs !== exp_out) begin
                n_fail++;
                $display("FAIL enable cyc=%0d got=%b want=%b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_random();
        bit r, e, u, d;
        logic [3:0] obs;
        u = 0; d = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0)  u = ~u;
            if ($urandom_range(11) == 0) d = ~d;
            e = ($urandom_range(24) != 0);
            r = ($urandom_range(99) == 0);
            step(r, e, u, d);
            obs = observed();
            n_checks++;
            if (obs !== exp_out || (obs[3] && obs[2])) begin
                n_fail++;
                $display("FAIL random cyc=%0d in(r,e,u,d)=%b%b%b%b got=%b want=%b",
                         i, r, e, u, d, obs, exp_out);
            end
        end
    endtask

    initial begin
        bus.EN      = 1'b1;
        bus.UP_IN   = 1'b1;
        bus.DOWN_IN = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single_press();
        test_conflict_same_cycle();
        test_down_then_up();
        test_auto_repeat();
        test_reset_mid_hold();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_step_request_scheduler
